// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - control-sequencer bus between IR/flags and control consumers
// Purpose: bundles the sequencer's opcode/flag inputs and control-word/status outputs.
// Ports (via modports):
//   master : drives enable, instruction, carry, zero; observes ctrlwrd, step, instr_done, halted
//   slave  : the sequencer side, the mirror of master
interface microcode_sequencer_if #(
    parameter int OPW   = 4,
    parameter int CWW   = 16,
    parameter int STEPS = 8
);
    localparam int STEPW = $clog2(STEPS);

    logic             enable;
    logic [OPW-1:0]   instruction;
    logic             carry;
    logic             zero;
    logic [CWW-1:0]   ctrlwrd;
    logic [STEPW-1:0] step;
    logic             instr_done;
    logic             halted;

    modport master (
        output enable, instruction, carry, zero,
        input  ctrlwrd, step, instr_done, halted
    );

    modport slave (
        input  enable, instruction, carry, zero,
        output ctrlwrd, step, instr_done, halted
    );
endinterface

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - step counter plus microcode decode for the CPU controller
// Purpose: sequences fetch/execute micro-steps, ends each instruction on its own last step,
//          supports conditional jumps on carry/zero and a sticky halt left only by reset.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; forces ctrlwrd/instr_done to 0 while asserted
//   bus    : slave side of microcode_sequencer_if (enable, instruction, carry, zero in;
//            ctrlwrd, step, instr_done, halted out)
module microcode_sequencer #(
    parameter int OPW   = 4,
    parameter int CWW   = 16,
    parameter int STEPS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    microcode_sequencer_if.slave  bus
);
    localparam int STEPW = $clog2(STEPS);

    localparam logic [15:0] B_J   = 16'h0001;
    localparam logic [15:0] B_CO  = 16'h0002;
    localparam logic [15:0] B_CE  = 16'h0004;
    localparam logic [15:0] B_OI  = 16'h0008;
    localparam logic [15:0] B_BI  = 16'h0010;
    localparam logic [15:0] B_SU  = 16'h0020;
    localparam logic [15:0] B_SO  = 16'h0040;
    localparam logic [15:0] B_AO  = 16'h0080;
    localparam logic [15:0] B_AI  = 16'h0100;
    localparam logic [15:0] B_II  = 16'h0200;
    localparam logic [15:0] B_IO  = 16'h0400;
    localparam logic [15:0] B_RO  = 16'h0800;
    localparam logic [15:0] B_RI  = 16'h1000;
    localparam logic [15:0] B_MI  = 16'h2000;
    localparam logic [15:0] B_HLT = 16'h4000;
    localparam logic [15:0] B_FI  = 16'h8000;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [STEPW-1:0] step_q, step_nxt;
    logic             halted_q, halted_nxt;
    logic [3:0]       op;
    logic [15:0]      cw_raw;
    logic             is_last;

    // Any set bit above the 4-bit opcode field turns the instruction into a NOP.
    generate
        if (OPW > 4) begin : g_wide_op
            assign op = (|bus.instruction[OPW-1:4]) ? 4'h0 : bus.instruction[3:0];
        end else begin : g_narrow_op
            assign op = bus.instruction[3:0];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_nxt;
            halted_q <= halted_nxt;
        end
    end

    // Microcode decode: raw control word and last-step marker for the current step/opcode.
    // A step past an opcode's last step (opcode changed mid-instruction) decodes to 0.
    always_comb begin
        cw_raw  = 16'h0000;
        is_last = 1'b0;
        case (step_q)
            STEPW'(0): cw_raw = B_CO | B_MI;
            STEPW'(1): cw_raw = B_RO | B_II | B_CE;
            STEPW'(2): begin
                is_last = 1'b1;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw_raw  = B_IO | B_MI;
                        is_last = 1'b0;
                    end
                    OP_OUT:  cw_raw = B_AO | B_OI;
                    OP_JMP:  cw_raw = B_IO | B_J;
                    OP_LDI:  cw_raw = B_IO | B_AI;
                    OP_JC:   cw_raw = bus.carry ? (B_IO | B_J) : 16'h0000;
                    OP_JZ:   cw_raw = bus.zero  ? (B_IO | B_J) : 16'h0000;
                    OP_HLT:  cw_raw = B_HLT;
                    default: cw_raw = 16'h0000;
                endcase
            end
            STEPW'(3): begin
                case (op)
                    OP_LDA: begin
                        cw_raw  = B_RO | B_AI;
                        is_last = 1'b1;
                    end
                    OP_ADD, OP_SUB: cw_raw = B_RO | B_BI;
                    OP_STA: begin
                        cw_raw  = B_AO | B_RI;
                        is_last = 1'b1;
                    end
                    default: cw_raw = 16'h0000;
                endcase
            end
            STEPW'(4): begin
                case (op)
                    OP_ADD: begin
                        cw_raw  = B_SO | B_AI | B_FI;
                        is_last = 1'b1;
                    end
                    OP_SUB: begin
                        cw_raw  = B_SO | B_SU | B_AI | B_FI;
                        is_last = 1'b1;
                    end
                    default: cw_raw = 16'h0000;
                endcase
            end
            default: cw_raw = 16'h0000;
        endcase
    end

    // Next-state logic
    always_comb begin
        step_nxt   = step_q;
        halted_nxt = halted_q;
        if (!halted_q && bus.enable) begin
            if (step_q == STEPW'(2) && op == OP_HLT) begin
                halted_nxt = 1'b1;
                step_nxt   = '0;
            end else if (is_last || step_q == STEPW'(STEPS - 1)) begin
                // The STEPS-1 term catches a runaway step when no last step was ever decoded.
                step_nxt = '0;
            end else begin
                step_nxt = step_q + STEPW'(1);
            end
        end
    end

    // Output logic: reset beats halt, halt beats enable.
    always_comb begin
        bus.ctrlwrd    = '0;
        bus.instr_done = 1'b0;
        if (reset) begin
            bus.ctrlwrd    = '0;
            bus.instr_done = 1'b0;
        end else if (halted_q) begin
            bus.ctrlwrd    = CWW'(B_HLT);
            bus.instr_done = 1'b0;
        end else if (bus.enable) begin
            bus.ctrlwrd    = CWW'(cw_raw);
            bus.instr_done = is_last;
        end
    end

    assign bus.step   = step_q;
    assign bus.halted = halted_q;
endmodule
